// File: rtl/tim_dual_bank.sv
// Word-interleaved banked TIM shared by a read-only fetch port and a read/write data port.
// Same-bank collisions are arbitrated; the losing request is buffered and served next cycle.
module tim_dual_bank #(
    parameter int          BANKS     = 4,
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ARB_MODE  = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    output logic        i_error,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,
    output logic [31:0] conflicts
);
    localparam int          LB    = (BANKS > 1) ? $clog2(BANKS) : 0;
    localparam int          BW    = (BANKS > 1) ? LB : 1;
    localparam int          RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [30:0] WORDS = 31'(BANKS * DEPTH);

    logic          i_pend_valid_reg, i_pend_valid_next;
    logic [29:0]   i_pend_word_reg, i_pend_word_next;
    logic          d_pend_valid_reg, d_pend_valid_next;
    logic [29:0]   d_pend_word_reg, d_pend_word_next;
    logic [31:0]   d_pend_wdata_reg, d_pend_wdata_next;
    logic [3:0]    d_pend_wstrb_reg, d_pend_wstrb_next;
    logic          rr_reg, rr_next;
    logic [31:0]   conflicts_reg, conflicts_next;
    logic          i_ready_reg, i_err_reg, d_ready_reg, d_err_reg, d_load_reg;
    logic [BW-1:0] i_bank_reg, d_bank_reg;

    logic          i_c_valid, d_c_valid, i_c_mem, d_c_mem, i_c_err, d_c_err;
    logic [29:0]   i_c_word, d_c_word, i_off, d_off;
    logic [31:0]   d_c_wdata;
    logic [3:0]    d_c_wstrb;
    logic          i_in_range, d_in_range;
    logic [BW-1:0] i_bank, d_bank;
    logic [RW-1:0] i_row, d_row;
    logic          collide, d_wins, i_go, d_go;
    logic [31:0]   bank_rdata [BANKS];
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // A buffered loser takes priority over whatever the same port would otherwise present.
    assign i_c_valid = i_pend_valid_reg | i_valid;
    assign d_c_valid = d_pend_valid_reg | d_valid;
    assign i_c_word  = i_pend_valid_reg ? i_pend_word_reg  : i_addr[31:2];
    assign d_c_word  = d_pend_valid_reg ? d_pend_word_reg  : d_addr[31:2];
    assign d_c_wdata = d_pend_valid_reg ? d_pend_wdata_reg : d_wdata;
    assign d_c_wstrb = d_pend_valid_reg ? d_pend_wstrb_reg : d_wstrb;

    assign i_off      = i_c_word - BASE_ADDR[31:2];
    assign d_off      = d_c_word - BASE_ADDR[31:2];
    assign i_in_range = {1'b0, i_off} < WORDS;
    assign d_in_range = {1'b0, d_off} < WORDS;
    assign i_bank     = (BANKS > 1) ? i_off[BW-1:0] : '0;
    assign d_bank     = (BANKS > 1) ? d_off[BW-1:0] : '0;
    assign i_row      = RW'(i_off >> LB);
    assign d_row      = RW'(d_off >> LB);

    assign i_c_mem = i_c_valid & i_in_range;
    assign d_c_mem = d_c_valid & d_in_range;
    assign i_c_err = i_c_valid & ~i_in_range;
    assign d_c_err = d_c_valid & ~d_in_range;
    assign collide = i_c_mem & d_c_mem & (i_bank == d_bank);

    always_comb begin
        d_wins = 1'b1;
        if (i_pend_valid_reg)
            d_wins = 1'b0;
        else if (d_pend_valid_reg)
            d_wins = 1'b1;
        else if (ARB_MODE != 0)
            d_wins = ~rr_reg;
    end

    assign i_go = i_c_mem & ~(collide & d_wins);
    assign d_go = d_c_mem & ~(collide & ~d_wins);

    always_comb begin
        i_pend_valid_next = collide & d_wins;
        i_pend_word_next  = i_c_word;
        d_pend_valid_next = collide & ~d_wins;
        d_pend_word_next  = d_c_word;
        d_pend_wdata_next = d_c_wdata;
        d_pend_wstrb_next = d_c_wstrb;
        rr_next           = rr_reg;
        conflicts_next    = conflicts_reg;
        if (collide && !i_pend_valid_reg && !d_pend_valid_reg)
            rr_next = ~rr_reg;
        if (collide && conflicts_reg != 32'hFFFF_FFFF)
            conflicts_next = conflicts_reg + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_pend_valid_reg <= 1'b0;
            i_pend_word_reg  <= '0;
            d_pend_valid_reg <= 1'b0;
            d_pend_word_reg  <= '0;
            d_pend_wdata_reg <= '0;
            d_pend_wstrb_reg <= '0;
            rr_reg           <= 1'b0;
            conflicts_reg    <= '0;
            i_ready_reg      <= 1'b0;
            i_err_reg        <= 1'b0;
            d_ready_reg      <= 1'b0;
            d_err_reg        <= 1'b0;
            d_load_reg       <= 1'b0;
            i_bank_reg       <= '0;
            d_bank_reg       <= '0;
        end else begin
            i_pend_valid_reg <= i_pend_valid_next;
            i_pend_word_reg  <= i_pend_word_next;
            d_pend_valid_reg <= d_pend_valid_next;
            d_pend_word_reg  <= d_pend_word_next;
            d_pend_wdata_reg <= d_pend_wdata_next;
            d_pend_wstrb_reg <= d_pend_wstrb_next;
            rr_reg           <= rr_next;
            conflicts_reg    <= conflicts_next;
            i_ready_reg      <= i_go | i_c_err;
            i_err_reg        <= i_c_err;
            d_ready_reg      <= d_go | d_c_err;
            d_err_reg        <= d_c_err;
            d_load_reg       <= d_go & (d_c_wstrb == 4'd0);
            i_bank_reg       <= i_bank;
            d_bank_reg       <= d_bank;
        end
    end

    // Each bank sees at most one access per edge, so a single-port RAM per bank suffices.
    genvar gi;
    for (gi = 0; gi < BANKS; gi++) begin : g_bank
        logic [31:0]   mem [DEPTH];
        logic [31:0]   rdata_reg;
        logic          d_sel, en;
        logic [RW-1:0] row;
        logic [3:0]    we;

        assign d_sel = d_go && (d_bank == BW'(gi));
        assign en    = d_sel || (i_go && (i_bank == BW'(gi)));
        assign row   = d_sel ? d_row : i_row;
        assign we    = d_sel ? d_c_wstrb : 4'b0000;

        always_ff @(posedge clock) begin
            if (en) begin
                rdata_reg <= mem[row];
                for (int b = 0; b < 4; b++) begin
                    if (we[b])
                        mem[row][8*b +: 8] <= d_c_wdata[8*b +: 8];
                end
            end
        end

        assign bank_rdata[gi] = rdata_reg;
    end

    assign i_ready   = i_ready_reg;
    assign i_error   = i_err_reg;
    assign i_rdata   = (i_ready_reg && !i_err_reg) ? bank_rdata[i_bank_reg] : 32'h0;
    assign d_ready   = d_ready_reg;
    assign d_error   = d_err_reg;
    assign d_rdata   = d_load_reg ? bank_rdata[d_bank_reg] : 32'h0;
    assign conflicts = conflicts_reg;
endmodule

// File: tb/tb_tim_dual_bank.sv
// Bench for tim_dual_bank: a fixed-priority and a round-robin instance share stimulus and are
// checked against a transaction-level model (word array, serialised winner-first access order).
module tb_tim_dual_bank;
    localparam int BANKS = 4;
    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_valid = 1'b0, d_valid = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;

    logic [1:0]  i_ready_w, i_error_w, d_ready_w, d_error_w;
    logic [31:0] i_rdata_w [2];
    logic [31:0] d_rdata_w [2];
    logic [31:0] conflicts_w [2];

    always #5 clock = ~clock;

    tim_dual_bank #(.BANKS(BANKS), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .ARB_MODE(0)) dut_fixed (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata_w[0]),
        .i_ready(i_ready_w[0]), .i_error(i_error_w[0]),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata_w[0]), .d_ready(d_ready_w[0]), .d_error(d_error_w[0]),
        .conflicts(conflicts_w[0])
    );

    tim_dual_bank #(.BANKS(BANKS), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .ARB_MODE(1)) dut_rr (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata_w[1]),
        .i_ready(i_ready_w[1]), .i_error(i_error_w[1]),
        .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata_w[1]), .d_ready(d_ready_w[1]), .d_error(d_error_w[1]),
        .conflicts(conflicts_w[1])
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          round_no = 0;
    logic [31:0] mem_m [64];
    int          rr_m [2];
    logic [31:0] conf_m [2];
    logic [31:0] last_d_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0)
            a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'h4000 + ($urandom_range(0, 1023) << 2);
        else
            a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
        return a;
    endfunction

    // One request per port (optional), then three observed cycles with full output checks.
    task automatic do_round(input logic iv, input logic [31:0] ia, input logic dv,
                            input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds);
        logic        ierr, derr, imem, dmem, coll, dfirst;
        logic [31:0] old_i, new_i, d_exp, merged;
        logic [31:0] iexp [2];
        int          icyc [2];
        int          dcyc [2];

        ierr  = iv && (ia[31:2] >= 30'(BANKS * DEPTH));
        derr  = dv && (da[31:2] >= 30'(BANKS * DEPTH));
        imem  = iv && !ierr;
        dmem  = dv && !derr;
        old_i = imem ? mem_m[ia[7:2]] : 32'h0;
        d_exp = (dmem && ds == 4'd0) ? mem_m[da[7:2]] : 32'h0;
        if (dmem && ds != 4'd0) begin
            merged = mem_m[da[7:2]];
            for (int b = 0; b < 4; b++)
                if (ds[b]) merged[8*b +: 8] = dw[8*b +: 8];
            mem_m[da[7:2]] = merged;
        end
        new_i = imem ? mem_m[ia[7:2]] : 32'h0;
        coll  = imem && dmem && (ia[3:2] == da[3:2]);
        for (int k = 0; k < 2; k++) begin
            dfirst  = (k == 0) || (rr_m[k] == 0);
            icyc[k] = !iv ? 0 : (coll && dfirst) ? 2 : 1;
            dcyc[k] = !dv ? 0 : (coll && !dfirst) ? 2 : 1;
            iexp[k] = ierr ? 32'h0 : (coll && dfirst) ? new_i : old_i;
            if (coll) begin
                conf_m[k] = conf_m[k] + 32'd1;
                rr_m[k]   = 1 - rr_m[k];
            end
        end

        round_no++;
        $display("round %0d: i=%0b@%h d=%0b@%h wdata=%h wstrb=%h collide=%0b",
                 round_no, iv, ia, dv, da, dw, ds, coll);
        i_valid = iv; i_addr = ia;
        d_valid = dv; d_addr = da; d_wdata = dw; d_wstrb = ds;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 1) begin
                i_valid = 1'b0;
                d_valid = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                check_eq($sformatf("r%0d u%0d c%0d i_ready", round_no, k, c), 32'(i_ready_w[k]), 32'(icyc[k] == c));
                check_eq($sformatf("r%0d u%0d c%0d i_error", round_no, k, c), 32'(i_error_w[k]), 32'(icyc[k] == c && ierr));
                check_eq($sformatf("r%0d u%0d c%0d i_rdata", round_no, k, c), i_rdata_w[k], (icyc[k] == c) ? iexp[k] : 32'h0);
                check_eq($sformatf("r%0d u%0d c%0d d_ready", round_no, k, c), 32'(d_ready_w[k]), 32'(dcyc[k] == c));
                check_eq($sformatf("r%0d u%0d c%0d d_error", round_no, k, c), 32'(d_error_w[k]), 32'(dcyc[k] == c && derr));
                check_eq($sformatf("r%0d u%0d c%0d d_rdata", round_no, k, c), d_rdata_w[k], (dcyc[k] == c) ? d_exp : 32'h0);
            end
            if (dcyc[0] == c)
                last_d_rdata = d_rdata_w[0];
        end
        for (int k = 0; k < 2; k++)
            check_eq($sformatf("r%0d u%0d conflicts", round_no, k), conflicts_w[k], conf_m[k]);
    endtask

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("%s u%0d i_ready", tag, k), 32'(i_ready_w[k]), 32'h0);
            check_eq($sformatf("%s u%0d i_rdata", tag, k), i_rdata_w[k], 32'h0);
            check_eq($sformatf("%s u%0d i_error", tag, k), 32'(i_error_w[k]), 32'h0);
            check_eq($sformatf("%s u%0d d_ready", tag, k), 32'(d_ready_w[k]), 32'h0);
            check_eq($sformatf("%s u%0d d_rdata", tag, k), d_rdata_w[k], 32'h0);
            check_eq($sformatf("%s u%0d d_error", tag, k), 32'(d_error_w[k]), 32'h0);
            check_eq($sformatf("%s u%0d conflicts", tag, k), conflicts_w[k], 32'h0);
        end
    endtask

    initial begin
        rr_m   = '{0, 0};
        conf_m = '{32'h0, 32'h0};

        // Reset held with activity on both ports: everything stays quiet.
        i_valid = 1'b1; i_addr = 32'h0; d_valid = 1'b1; d_addr = 32'h10; d_wstrb = 4'h0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check_idle($sformatf("in_reset c%0d", c));
        end
        i_valid = 1'b0; d_valid = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check_idle($sformatf("after_reset c%0d", c));
        end

        // Preload every word the bench will touch.
        for (int w = 0; w < 64; w++)
            do_round(1'b0, 32'h0, 1'b1, 32'(w * 4), $urandom, 4'hF);

        // Reset while a collision loser is buffered: it must never answer.
        i_valid = 1'b1; i_addr = 32'h0; d_valid = 1'b1; d_addr = 32'h10; d_wstrb = 4'h0;
        next_cycle();
        i_valid = 1'b0; d_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_idle("mid_reset");
        next_cycle();
        reset = 1'b1;
        rr_m   = '{0, 0};
        conf_m = '{32'h0, 32'h0};
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            check_idle($sformatf("dropped_pending c%0d", c));
        end

        // Parallel access on different banks.
        do_round(1'b1, 32'h0, 1'b1, 32'h4, 32'h0, 4'h0);

        // Three back-to-back same-bank collisions: round-robin winners d, i, d.
        do_round(1'b1, 32'h0,  1'b1, 32'h10, 32'h0, 4'h0);
        do_round(1'b1, 32'h24, 1'b1, 32'h34, 32'h0, 4'h0);
        do_round(1'b1, 32'h8,  1'b1, 32'h18, 32'h0, 4'h0);
        check_eq("rr_three_collisions", conflicts_w[1], 32'd3);

        // Fixed-priority collision on bank 0.
        do_round(1'b1, 32'h0, 1'b1, 32'h10, 32'h0, 4'h0);
        check_eq("fixed_four_collisions", conflicts_w[0], 32'd4);

        // Byte-strobe store followed by a load of the same word.
        do_round(1'b0, 32'h0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
        do_round(1'b0, 32'h0, 1'b1, 32'h8, 32'h11223344, 4'b0101);
        do_round(1'b0, 32'h0, 1'b1, 32'h8, 32'h0, 4'h0);
        check_eq("byte_merge", last_d_rdata, 32'hAA22CC44);

        // Out-of-range store aliasing bank 0 row 0, collided against a fetch of word 0.
        do_round(1'b1, 32'h0, 1'b1, 32'(BANKS * DEPTH * 4), 32'hDEADBEEF, 4'hF);
        do_round(1'b0, 32'h0, 1'b1, 32'h0, 32'h0, 4'h0);

        // Store on one port, fetch of the same word on the other, then random traffic.
        do_round(1'b1, 32'h40, 1'b1, 32'h40, 32'h5A5A_A5A5, 4'hF);
        do_round(1'b1, 32'h40, 1'b1, 32'h40, 32'h0, 4'h0);
        for (int r = 0; r < 200; r++) begin
            logic iv, dv;
            iv = ($urandom_range(0, 3) != 0);
            dv = ($urandom_range(0, 3) != 0);
            do_round(iv, rand_addr(), dv, rand_addr(), $urandom,
                     ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
